wb_port_arbiter: RTL and testbench

- Shares the single register-file write-back port between the primary datapath result and seven auxiliary write-back sources, such as HI/LO, CP0 and multi-cycle MDU results.
- Drives the 7-bit one-hot select and the "b" data input of the 32-bit write-back 2:1 mux. opt=0 selects the primary result; a single set bit selects the auxiliary value.
- Arbitration is round-robin with anti-starvation preemption of the primary path.
- Multi-beat bursts (e.g. HI then LO) hold the port until their last beat.

---
 rtl/wb_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-back port arbiter: the primary datapath result versus seven
// auxiliary sources. Round-robin, with starvation preemption and multi-beat bursts.

module wb_wait_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       gnt,
    output logic       starved
);
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               cnt <= '0;
        else if (gnt || !req)     cnt <= '0;
        else if (cnt != 4'd15)    cnt <= cnt + 4'd1;
    end

    assign starved = req && (cnt >= 4'(MAX_WAIT));
endmodule

module wb_port_arbiter #(
    parameter int DW       = 32,
    parameter int NREQ     = 7,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pri_we,
    input  logic [NREQ-1:0]    aux_req,
    input  logic [NREQ-1:0]    aux_last,
    input  logic [NREQ*DW-1:0] aux_data,
    output logic [NREQ-1:0]    aux_gnt,
    output logic [NREQ-1:0]    opt,
    output logic [DW-1:0]      wb_b,
    output logic               pri_stall
);
    typedef enum logic {IDLE, BURST} st_t;

    st_t             fsm, fsm_nxt;
    logic [2:0]      owner, owner_nxt, rr_ptr, rr_nxt;
    logic [NREQ-1:0] starved, gnt;
    logic            stall;
    logic            gv;
    logic [2:0]      gsel;
    logic [3:0]      starve_pick, req_pick;

    for (genvar i = 0; i < NREQ; i++) begin : g_wait
        wb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (aux_req[i]),
            .gnt     (gnt[i]),
            .starved (starved[i])
        );
    end

    // Returns {found, index} of the first set bit at or after ptr, wrapping at NREQ.
    function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] v, input logic [2:0] ptr);
        logic       found;
        logic [2:0] sel;
        int         j;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && v[j]) begin
                found = 1'b1;
                sel   = 3'(j);
            end
        end
        return {found, sel};
    endfunction

    always_comb begin
        gnt         = '0;
        stall       = 1'b0;
        gv          = 1'b0;
        gsel        = '0;
        fsm_nxt     = fsm;
        owner_nxt   = owner;
        rr_nxt      = rr_ptr;
        starve_pick = rr_pick(starved, rr_ptr);
        req_pick    = rr_pick(aux_req, rr_ptr);
        case (fsm)
            IDLE: begin
                if (starve_pick[3]) begin
                    gv    = 1'b1;
                    gsel  = starve_pick[2:0];
                    stall = pri_we;
                end else if (!pri_we && req_pick[3]) begin
                    gv   = 1'b1;
                    gsel = req_pick[2:0];
                end
                if (gv) begin
                    gnt[gsel] = 1'b1;
                    rr_nxt    = (gsel == 3'(NREQ-1)) ? 3'd0 : gsel + 3'd1;
                    if (!aux_last[gsel]) begin
                        fsm_nxt   = BURST;
                        owner_nxt = gsel;
                    end
                end
            end
            BURST: begin
                stall = pri_we;
                if (aux_req[owner]) begin
                    gnt[owner] = 1'b1;
                    if (aux_last[owner]) fsm_nxt = IDLE;
                end else begin
                    // Owner abandoned the burst: release the port, re-arbitrate next cycle.
                    fsm_nxt = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm    <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            fsm    <= fsm_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Outputs are forced low while reset is asserted so a mid-burst reset drops the grant at once.
    always_comb begin
        aux_gnt   = rst_n ? gnt : '0;
        opt       = aux_gnt;
        pri_stall = rst_n & stall;
        wb_b      = '0;
        for (int i = 0; i < NREQ; i++)
            if (aux_gnt[i]) wb_b = aux_data[i*DW +: DW];
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, round-robin, starvation, burst, abort, async reset.

module tb_wb_port_arbiter;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          pri_we;
    logic [6:0]    aux_req, aux_last;
    logic [223:0]  aux_data;
    logic [6:0]    aux_gnt, opt;
    logic [31:0]   wb_b;
    logic          pri_stall;
    logic [31:0]   d [7];
    int            ntest = 0;
    int            nfail = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DW(32), .NREQ(7), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pri_we    (pri_we),
        .aux_req   (aux_req),
        .aux_last  (aux_last),
        .aux_data  (aux_data),
        .aux_gnt   (aux_gnt),
        .opt       (opt),
        .wb_b      (wb_b),
        .pri_stall (pri_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] eg, input logic [31:0] eb, input logic es);
        #1;
        ntest++;
        assert ({aux_gnt, opt, wb_b, pri_stall} === {eg, eg, eb, es}) else begin
            nfail++;
            $error("FAIL %s: got gnt=%h opt=%h wb_b=%h stall=%b, want gnt=%h opt=%h wb_b=%h stall=%b",
                   tag, aux_gnt, opt, wb_b, pri_stall, eg, eg, eb, es);
        end
    endtask

    initial begin
        d[0] = 32'h0000_1111; d[1] = 32'h1234_5678; d[2] = 32'hDEAD_BEEF;
        d[3] = 32'hCAFE_0003; d[4] = 32'h4444_0004; d[5] = 32'hA5A5_0005;
        d[6] = 32'h6666_0006;
        for (int i = 0; i < 7; i++) aux_data[i*32 +: 32] = d[i];

        // reset holds every output low regardless of inputs
        rst_n = 1'b0; pri_we = 1'b1; aux_req = 7'h7F; aux_last = 7'h7F;
        chk("reset", 7'h00, 32'h0, 1'b0);
        pri_we = 1'b0; aux_req = 7'h00; rst_n = 1'b1;
        chk("idle", 7'h00, 32'h0, 1'b0);
        tick();

        // round-robin between requesters 0 and 2
        aux_req = 7'b0000101;
        chk("rr0", 7'h01, d[0], 1'b0); tick();
        chk("rr1", 7'h04, 32'hDEAD_BEEF, 1'b0); tick();
        chk("rr2", 7'h01, d[0], 1'b0); tick();
        chk("rr3", 7'h04, 32'hDEAD_BEEF, 1'b0);
        aux_req = 7'h00; tick();

        // primary wins for four cycles, then requester 3 preempts (rr_ptr=3)
        pri_we = 1'b1; aux_req = 7'h08;
        for (int c = 0; c < 4; c++) begin
            chk("starve_wait", 7'h00, 32'h0, 1'b0); tick();
        end
        chk("starve_gnt", 7'h08, d[3], 1'b1); tick();
        chk("starve_after", 7'h00, 32'h0, 1'b0);
        aux_req = 7'h00; pri_we = 1'b0; tick();

        // requester 1 starves into a 2-beat burst while 5 and primary wait (rr_ptr=4)
        pri_we = 1'b1; aux_last[1] = 1'b0; aux_req = 7'b0000010;
        chk("bst_c0", 7'h00, 32'h0, 1'b0); tick();
        chk("bst_c1", 7'h00, 32'h0, 1'b0); tick();
        aux_req = 7'b0100010;
        chk("bst_c2", 7'h00, 32'h0, 1'b0); tick();
        chk("bst_c3", 7'h00, 32'h0, 1'b0); tick();
        chk("bst_beat1", 7'h02, d[1], 1'b1); tick();
        aux_last[1] = 1'b1;
        chk("bst_beat2", 7'h02, d[1], 1'b1); tick();
        aux_req = 7'b0100000;
        chk("bst_r5_starved", 7'h20, d[5], 1'b1); tick();
        aux_req = 7'h00; pri_we = 1'b0; tick();

        // requester 6 aborts a burst; pointer wraps to 0 (rr_ptr=6)
        aux_last[6] = 1'b0; aux_req = 7'h40;
        chk("abort_beat1", 7'h40, d[6], 1'b0); tick();
        aux_req = 7'h00;
        chk("abort_drop", 7'h00, 32'h0, 1'b0); tick();
        aux_req = 7'h41;
        chk("abort_wrap", 7'h01, d[0], 1'b0); tick();
        aux_req = 7'h00; aux_last = 7'h7F; tick();

        // asynchronous reset in the middle of a burst
        aux_last[2] = 1'b0; aux_req = 7'h04; pri_we = 1'b0;
        chk("ar_beat1", 7'h04, 32'hDEAD_BEEF, 1'b0); tick();
        pri_we = 1'b1;
        chk("ar_beat2", 7'h04, 32'hDEAD_BEEF, 1'b1);
        #1 rst_n = 1'b0;
        chk("ar_inreset", 7'h00, 32'h0, 1'b0);
        #1 rst_n = 1'b1;
        chk("ar_idle", 7'h00, 32'h0, 1'b0); tick();
        chk("ar_idle2", 7'h00, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
